// File: rtl/frame_tx_scheduler_if.sv
// Serial accelerometer link bus between the sample-source front ends and the
// frame scheduler.
//   req         per-source sample-pending request
//   data_in     per-source {x,y,z} words; source i at [i*3*DATA_W +: 3*DATA_W]
//   ack         one-cycle grant/latch pulse per source
//   sclk, fsync bit clock and frame strobe
//   x/y/z_out   serial data lanes, MSB first
//   src_id      source index of the current frame
//   frame_valid high while payload bits of a granted frame are on the lanes
interface frame_tx_scheduler_if #(
    parameter int DATA_W = 14,
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2
);
    logic [N_REQ-1:0]          req;
    logic [N_REQ*3*DATA_W-1:0] data_in;
    logic [N_REQ-1:0]          ack;
    logic                      sclk;
    logic                      fsync;
    logic                      x_out;
    logic                      y_out;
    logic                      z_out;
    logic [ID_W-1:0]           src_id;
    logic                      frame_valid;

    modport slave (
        input  req, data_in,
        output ack, sclk, fsync, x_out, y_out, z_out, src_id, frame_valid
    );

    modport master (
        output req, data_in,
        input  ack, sclk, fsync, x_out, y_out, z_out, src_id, frame_valid
    );
endinterface

// File: rtl/frame_tx_scheduler.sv
// Frame scheduler and round-robin arbiter for the serial accelerometer link.
// Divides CLK into bit periods (sclk) and frames (fsync), grants one source per
// frame and shifts its 14-bit x/y/z words out on three lanes, MSB first.
//   CLK  main clock
//   RST  asynchronous active-low reset
//   bus  frame_tx_scheduler_if.slave (requests/data in, serial link out)
//
// state | meaning
// SYNC  | bit 0: fsync high, lanes low; arbitration happened on entry
// SHIFT | bits 1..DATA_W: payload of the granted source (lanes low if empty)
// GAP   | bits DATA_W+1..FRAME_BITS-1: idle; also the reset state so the
//       | first edge after reset enters SYNC
module frame_tx_scheduler #(
    parameter int BIT_DIV    = 5400,
    parameter int FRAME_BITS = 100,
    parameter int DATA_W     = 14,
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    frame_tx_scheduler_if.slave  bus
);
    localparam int DIV_W   = $clog2(BIT_DIV);
    localparam int BIT_W   = $clog2(FRAME_BITS);
    localparam int WORD3_W = 3 * DATA_W;

    typedef enum logic [1:0] {SYNC, SHIFT, GAP} state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     src_id_q;
    logic                granted_q;
    logic [DATA_W-1:0]   x_sh_q, y_sh_q, z_sh_q;
    logic [N_REQ-1:0]    ack_q;
    logic                sclk_q, fsync_q, x_q, y_q, z_q, fv_q;

    logic [2**ID_W-1:0]  req_ext;
    logic                arb_found;
    logic [ID_W-1:0]     src_id_d;
    logic [ID_W-1:0]     rr_ptr_d;
    logic [N_REQ-1:0]    ack_d;
    logic [WORD3_W-1:0]  word_d;

    // Round-robin pick: first asserted request scanning from rr_ptr upward.
    always_comb begin
        int cand;
        cand      = 0;
        req_ext   = '0;
        req_ext[N_REQ-1:0] = bus.req;
        arb_found = 1'b0;
        src_id_d  = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!arb_found && req_ext[ID_W'(cand)]) begin
                arb_found = 1'b1;
                src_id_d  = ID_W'(cand);
            end
        end
        rr_ptr_d = (int'(src_id_d) == N_REQ - 1) ? '0 : src_id_d + ID_W'(1);
        ack_d    = '0;
        word_d   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (src_id_d == ID_W'(i)) begin
                ack_d[i] = arb_found;
                word_d   = bus.data_in[i*WORD3_W +: WORD3_W];
            end
        end
    end

    // div_cnt/bit_cnt hold the position of the cycle the next edge produces,
    // so every output is registered and changes exactly on a bit start.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= GAP;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            rr_ptr_q  <= '0;
            src_id_q  <= '0;
            granted_q <= 1'b0;
            x_sh_q    <= '0;
            y_sh_q    <= '0;
            z_sh_q    <= '0;
            ack_q     <= '0;
            sclk_q    <= 1'b1;
            fsync_q   <= 1'b0;
            x_q       <= 1'b0;
            y_q       <= 1'b0;
            z_q       <= 1'b0;
            fv_q      <= 1'b0;
        end else begin
            ack_q  <= '0;
            sclk_q <= (div_cnt_q >= DIV_W'(BIT_DIV / 2));
            if (div_cnt_q == DIV_W'(BIT_DIV - 1)) div_cnt_q <= '0;
            else                                   div_cnt_q <= div_cnt_q + 1'b1;

            if (div_cnt_q == '0) begin
                if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) bit_cnt_q <= '0;
                else                                     bit_cnt_q <= bit_cnt_q + 1'b1;
                fsync_q <= 1'b0;
                x_q     <= 1'b0;
                y_q     <= 1'b0;
                z_q     <= 1'b0;
                fv_q    <= 1'b0;
                case (state_q)
                    GAP: begin
                        if (bit_cnt_q == '0) begin
                            state_q   <= SYNC;
                            fsync_q   <= 1'b1;
                            granted_q <= arb_found;
                            // Empty frame leaves src_id and rr_ptr untouched.
                            if (arb_found) begin
                                ack_q    <= ack_d;
                                src_id_q <= src_id_d;
                                rr_ptr_q <= rr_ptr_d;
                                {x_sh_q, y_sh_q, z_sh_q} <= word_d;
                            end
                        end
                    end
                    SYNC, SHIFT: begin
                        if (bit_cnt_q == BIT_W'(DATA_W + 1)) begin
                            state_q <= GAP;
                        end else begin
                            state_q <= SHIFT;
                            if (granted_q) begin
                                x_q    <= x_sh_q[DATA_W-1];
                                y_q    <= y_sh_q[DATA_W-1];
                                z_q    <= z_sh_q[DATA_W-1];
                                fv_q   <= 1'b1;
                                x_sh_q <= {x_sh_q[DATA_W-2:0], 1'b0};
                                y_sh_q <= {y_sh_q[DATA_W-2:0], 1'b0};
                                z_sh_q <= {z_sh_q[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    default: state_q <= GAP;
                endcase
            end
        end
    end

    assign bus.ack         = ack_q;
    assign bus.sclk        = sclk_q;
    assign bus.fsync       = fsync_q;
    assign bus.x_out       = x_q;
    assign bus.y_out       = y_q;
    assign bus.z_out       = z_q;
    assign bus.src_id      = src_id_q;
    assign bus.frame_valid = fv_q;
endmodule

// File: tb/tb_frame_tx_scheduler.sv
module tb_frame_tx_scheduler;
    localparam int BIT_DIV    = 8;
    localparam int FRAME_BITS = 20;
    localparam int DATA_W     = 14;
    localparam int N_REQ      = 4;
    localparam int ID_W       = 2;
    localparam int W3         = 3 * DATA_W;
    localparam int FRAME_CYC  = BIT_DIV * FRAME_BITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    frame_tx_scheduler_if #(.DATA_W(DATA_W), .N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    frame_tx_scheduler #(
        .BIT_DIV(BIT_DIV), .FRAME_BITS(FRAME_BITS), .DATA_W(DATA_W),
        .N_REQ(N_REQ), .ID_W(ID_W)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: position-in-frame arithmetic plus round-robin scan.
    int                pos;
    int                m_rr;
    int                m_src;
    logic              m_gnt;
    logic [DATA_W-1:0] m_x, m_y, m_z;
    logic [N_REQ-1:0]  m_ack;
    logic [11:0]       exp_vec;

    function automatic logic [11:0] obs();
        return {bus.sclk, bus.fsync, bus.x_out, bus.y_out, bus.z_out,
                bus.frame_valid, bus.ack, bus.src_id};
    endfunction

    function automatic void model_reset();
        pos     = -1;
        m_rr    = 0;
        m_src   = 0;
        m_gnt   = 1'b0;
        m_x     = '0;
        m_y     = '0;
        m_z     = '0;
        m_ack   = '0;
        exp_vec = {1'b1, 1'b0, 3'b000, 1'b0, 4'b0000, 2'b00};
    endfunction

    function automatic void model_edge();
        int d, b, k;
        logic [W3-1:0] w;
        logic xb, yb, zb, fv;
        pos++;
        d = pos % BIT_DIV;
        b = (pos / BIT_DIV) % FRAME_BITS;
        m_ack = '0;
        if (d == 0 && b == 0) begin
            m_gnt = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                k = (m_rr + i) % N_REQ;
                if (!m_gnt && ((bus.req >> k) & 4'd1) != 4'd0) begin
                    m_gnt = 1'b1;
                    m_src = k;
                    w     = W3'(bus.data_in >> (k * W3));
                    m_x   = w[3*DATA_W-1 -: DATA_W];
                    m_y   = w[2*DATA_W-1 -: DATA_W];
                    m_z   = w[DATA_W-1:0];
                    m_ack = 4'(1 << k);
                end
            end
            if (m_gnt) m_rr = (m_src + 1) % N_REQ;
        end
        fv = m_gnt && b >= 1 && b <= DATA_W;
        xb = 1'b0; yb = 1'b0; zb = 1'b0;
        if (fv) begin
            xb = m_x[4'(DATA_W - b)];
            yb = m_y[4'(DATA_W - b)];
            zb = m_z[4'(DATA_W - b)];
        end
        exp_vec = {d >= BIT_DIV / 2, b == 0, xb, yb, zb, fv, m_ack, 2'(m_src)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic set_words(input int s, input logic [DATA_W-1:0] x, y, z);
        logic [N_REQ*W3-1:0] mask, val;
        mask = {{(N_REQ*W3-W3){1'b0}}, {W3{1'b1}}} << (s * W3);
        val  = {{(N_REQ*W3-W3){1'b0}}, x, y, z} << (s * W3);
        bus.data_in = (bus.data_in & ~mask) | val;
    endtask

    function automatic logic [DATA_W-1:0] rnd14();
        return DATA_W'($urandom);
    endfunction

    task automatic quick_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int fs_cnt, ack_cnt, hi_cnt;
        bus.req     = '0;
        bus.data_in = '0;
        for (int s = 0; s < N_REQ; s++) set_words(s, rnd14(), rnd14(), rnd14());
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        if (obs() !== exp_vec) begin
            errors++; $display("FAIL reset_async got=%b exp=%b", obs(), exp_vec);
        end
        checks++;
        repeat (3) begin
            @(posedge clk); #1;
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL reset_hold got=%b exp=%b", obs(), exp_vec);
            end
            checks++;
        end
        rst_n = 1'b1;
        fs_cnt = 0; ack_cnt = 0; hi_cnt = 0;
        for (int c = 0; c < 2 * FRAME_CYC; c++) begin
            tick();
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL idle pos=%0d got=%b exp=%b", pos, obs(), exp_vec);
            end
            checks++;
            fs_cnt  += int'(bus.fsync);
            hi_cnt  += int'(bus.sclk);
            ack_cnt += (bus.ack != '0) ? 1 : 0;
        end
        if (fs_cnt !== 16) begin
            errors++; $display("FAIL idle_fsync_count got=%0d exp=16", fs_cnt);
        end
        checks++;
        if (hi_cnt !== FRAME_CYC) begin
            errors++; $display("FAIL idle_sclk_high got=%0d exp=%0d", hi_cnt, FRAME_CYC);
        end
        checks++;
        if (ack_cnt !== 0) begin
            errors++; $display("FAIL idle_ack got=%0d exp=0", ack_cnt);
        end
        checks++;
    endtask

    task automatic test_single_grant();
        logic [DATA_W-1:0] xs, ys, zs;
        logic [4:0] first;
        int b, ack_cnt, fv_cnt;
        xs = '0; ys = '0; zs = '0; ack_cnt = 0; fv_cnt = 0; first = '0;
        set_words(2, 14'h2A5C, 14'h0001, 14'h3FFF);
        bus.req = 4'b0100;
        for (int c = 0; c < FRAME_CYC; c++) begin
            tick();
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL single pos=%0d got=%b exp=%b", pos, obs(), exp_vec);
            end
            checks++;
            if (c == 0) first = {bus.fsync, bus.ack};
            if (m_ack != '0) bus.req = '0;
            ack_cnt += (bus.ack != '0) ? 1 : 0;
            fv_cnt  += int'(bus.frame_valid);
            b = (pos / BIT_DIV) % FRAME_BITS;
            if (pos % BIT_DIV == 0 && b >= 1 && b <= DATA_W) begin
                xs[4'(DATA_W - b)] = bus.x_out;
                ys[4'(DATA_W - b)] = bus.y_out;
                zs[4'(DATA_W - b)] = bus.z_out;
            end
        end
        if (first !== 5'b10100) begin
            errors++; $display("FAIL single_ack_with_fsync got=%b exp=10100", first);
        end
        checks++;
        if (bus.src_id !== 2'd2) begin
            errors++; $display("FAIL single_src_id got=%0d exp=2", bus.src_id);
        end
        checks++;
        if (ack_cnt !== 1) begin
            errors++; $display("FAIL single_ack_count got=%0d exp=1", ack_cnt);
        end
        checks++;
        if (xs !== 14'h2A5C || ys !== 14'h0001 || zs !== 14'h3FFF) begin
            errors++; $display("FAIL single_lanes got=%h/%h/%h exp=2a5c/0001/3fff", xs, ys, zs);
        end
        checks++;
        if (fv_cnt !== DATA_W * BIT_DIV) begin
            errors++; $display("FAIL single_fv_len got=%0d exp=%0d", fv_cnt, DATA_W * BIT_DIV);
        end
        checks++;
    endtask

    task automatic test_round_robin();
        int got[$];
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        int ack_total;
        ack_total = 0;
        quick_reset();
        for (int s = 0; s < N_REQ; s++) set_words(s, rnd14(), rnd14(), rnd14());
        bus.req = 4'b1111;
        for (int c = 0; c < 5 * FRAME_CYC; c++) begin
            tick();
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL rr pos=%0d got=%b exp=%b", pos, obs(), exp_vec);
            end
            checks++;
            if (c % FRAME_CYC == 0 && bus.ack != '0) got.push_back(int'(bus.src_id));
            ack_total += $countones(bus.ack);
            if (m_ack != '0) set_words(m_src, rnd14(), rnd14(), rnd14());
        end
        if (got.size() !== 5) begin
            errors++; $display("FAIL rr_grant_count got=%0d exp=5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (got[i] !== exp_rr[i]) begin
                    errors++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, got[i], exp_rr[i]);
                end
                checks++;
            end
        end
        checks++;
        if (ack_total !== 5) begin
            errors++; $display("FAIL rr_ack_total got=%0d exp=5", ack_total);
        end
        checks++;
    endtask

    task automatic test_late_drop();
        logic [DATA_W-1:0] x3, y3, z3, xs, ys, zs;
        logic [N_REQ-1:0] g_ack;
        logic [ID_W-1:0]  g_src;
        int b;
        x3 = rnd14(); y3 = rnd14(); z3 = rnd14();
        xs = '0; ys = '0; zs = '0; g_ack = '0; g_src = '0;
        set_words(3, x3, y3, z3);
        set_words(1, rnd14(), rnd14(), rnd14());
        bus.req = '0;
        for (int c = 0; c < 2 * FRAME_CYC; c++) begin
            tick();
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL late_drop pos=%0d got=%b exp=%b", pos, obs(), exp_vec);
            end
            checks++;
            if (c == 0) bus.req = 4'b1010;
            if (c == FRAME_CYC - 2) bus.req = 4'b1000;
            if (c == FRAME_CYC) begin
                g_ack = bus.ack; g_src = bus.src_id; bus.req = '0;
            end
            if (c == FRAME_CYC + 5 * BIT_DIV + 3) set_words(3, rnd14(), rnd14(), rnd14());
            b = (pos / BIT_DIV) % FRAME_BITS;
            if (c > FRAME_CYC && pos % BIT_DIV == 0 && b >= 1 && b <= DATA_W) begin
                xs[4'(DATA_W - b)] = bus.x_out;
                ys[4'(DATA_W - b)] = bus.y_out;
                zs[4'(DATA_W - b)] = bus.z_out;
            end
        end
        if (g_ack !== 4'b1000 || g_src !== 2'd3) begin
            errors++; $display("FAIL late_drop_grant got=%b/%0d exp=1000/3", g_ack, g_src);
        end
        checks++;
        if (xs !== x3 || ys !== y3 || zs !== z3) begin
            errors++; $display("FAIL late_data got=%h/%h/%h exp=%h/%h/%h", xs, ys, zs, x3, y3, z3);
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        logic [N_REQ-1:0] g_ack;
        logic [ID_W-1:0]  g_src;
        g_ack = '0; g_src = '0;
        for (int s = 0; s < N_REQ; s++) set_words(s, rnd14(), rnd14(), rnd14());
        bus.req = 4'b0110;
        for (int c = 0; c <= 7 * BIT_DIV + 2; c++) begin
            tick();
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL pre_rst pos=%0d got=%b exp=%b", pos, obs(), exp_vec);
            end
            checks++;
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        if (obs() !== exp_vec) begin
            errors++; $display("FAIL midframe_rst_async got=%b exp=%b", obs(), exp_vec);
        end
        checks++;
        repeat (2) begin
            @(posedge clk); #1;
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL midframe_rst_hold got=%b exp=%b", obs(), exp_vec);
            end
            checks++;
        end
        rst_n = 1'b1;
        bus.req = 4'b1111;
        for (int c = 0; c < FRAME_CYC; c++) begin
            tick();
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL post_rst pos=%0d got=%b exp=%b", pos, obs(), exp_vec);
            end
            checks++;
            if (c == 0) begin
                g_ack = bus.ack; g_src = bus.src_id;
            end
        end
        if (g_ack !== 4'b0001 || g_src !== 2'd0) begin
            errors++; $display("FAIL post_rst_grant got=%b/%0d exp=0001/0", g_ack, g_src);
        end
        checks++;
    endtask

    task automatic test_empty_frame();
        logic [5:0] got[3];
        logic [5:0] want[3] = '{6'b0010_01, 6'b0000_01, 6'b0100_10};
        for (int s = 0; s < N_REQ; s++) set_words(s, rnd14(), rnd14(), rnd14());
        bus.req = 4'b1111;
        for (int c = 0; c < 3 * FRAME_CYC; c++) begin
            tick();
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL empty pos=%0d got=%b exp=%b", pos, obs(), exp_vec);
            end
            checks++;
            if (c % FRAME_CYC == 0) got[c / FRAME_CYC] = {bus.ack, bus.src_id};
            if (c == 0) bus.req = '0;
            if (c == FRAME_CYC + 40) bus.req = 4'b1111;
        end
        for (int i = 0; i < 3; i++) begin
            if (got[i] !== want[i]) begin
                errors++; $display("FAIL empty_seq frame=%0d got=%b exp=%b", i, got[i], want[i]);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        int s;
        bus.req = '0;
        for (int c = 0; c < 10 * FRAME_CYC; c++) begin
            tick();
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL random pos=%0d got=%b exp=%b", pos, obs(), exp_vec);
            end
            checks++;
            if (m_ack != '0) begin
                if ($urandom_range(1, 0) == 0) bus.req = bus.req & ~m_ack;
                else set_words(m_src, rnd14(), rnd14(), rnd14());
            end
            if ($urandom_range(39, 0) == 0) begin
                s = int'($urandom_range(N_REQ - 1, 0));
                if (((bus.req >> s) & 4'd1) == 4'd0) set_words(s, rnd14(), rnd14(), rnd14());
                bus.req = bus.req ^ 4'(1 << s);
            end
        end
    endtask

    initial begin
        bus.req     = '0;
        bus.data_in = '0;
        model_reset();
        test_reset();
        test_single_grant();
        test_round_robin();
        test_late_drop();
        test_reset_midframe();
        test_empty_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
